flag_cond_unit: RTL and testbench

Registered PSW-style flag store and condition evaluator on the ALU's output side. It captures the Z/N/C/V flags produced by the ALU, feeds the stored carry back to the ALU carry-in, and resolves branch/compare conditions through a valid/ready handshake. It also drives PA-RISC-style nullification of the instruction(s) following a taken conditional.

---
 rtl/flag_cond_unit.sv | 156 +++++++++++++++
 tb/tb_flag_cond_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: registered Z/N/C/V flag store with a handshaked condition
// evaluator and optional PA-RISC-style nullification of retiring instructions.
// Optional feature macro: FLAG_NULLIFY_EN (NULL state, slot counter, squash).
module flag_cond_unit #(
  parameter int unsigned NULLIFY_SLOTS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       z_in,
  input  logic       n_in,
  input  logic       c_in,
  input  logic       v_in,
  output logic [3:0] flags_out,
  output logic       ci_out,
  input  logic       cond_valid,
  output logic       cond_ready,
  input  logic [3:0] cond_code,
  input  logic       cond_neg,
  input  logic       cond_nullify,
  output logic       res_valid,
  output logic       res_taken,
  input  logic       res_ready,
  input  logic       instr_valid,
  output logic       squash
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESULT = 2'd1,
    ST_NULL   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       res_taken_q, res_taken_d;

  logic [3:0] evalFlags;
  logic       evalRaw;
  logic       takenNow;

`ifdef FLAG_NULLIFY_EN
  localparam logic [3:0] SlotsInit = 4'(NULLIFY_SLOTS);

  logic       null_req_q, null_req_d;
  logic [3:0] count_q, count_d;
`else
  logic       unusedCfg;
  assign unusedCfg = ^{cond_nullify, instr_valid, 4'(NULLIFY_SLOTS)};
`endif

  // Flag register: capture ALU flags on flag_we, otherwise hold.
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {z_in, n_in, c_in, v_in};
    end
  end

  // Condition evaluation; incoming flags bypass the register when written in the same cycle.
  always_comb begin
    evalFlags = flag_we ? {z_in, n_in, c_in, v_in} : flags_q;
    evalRaw   = 1'b0;
    unique case (cond_code)
      4'd1:    evalRaw = evalFlags[3];
      4'd2:    evalRaw = evalFlags[2] ^ evalFlags[0];
      4'd3:    evalRaw = (evalFlags[2] ^ evalFlags[0]) | evalFlags[3];
      4'd4:    evalRaw = evalFlags[1];
      4'd5:    evalRaw = evalFlags[1] | evalFlags[3];
      4'd6:    evalRaw = evalFlags[0];
      4'd7:    evalRaw = evalFlags[2];
      default: evalRaw = 1'b0;
    endcase
    takenNow = evalRaw ^ cond_neg;
  end

  // Handshake FSM next-state logic; squash is the only combinational output.
  always_comb begin
    state_d     = state_q;
    res_taken_d = res_taken_q;
    squash      = 1'b0;
`ifdef FLAG_NULLIFY_EN
    null_req_d  = null_req_q;
    count_d     = count_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cond_valid) begin
          state_d     = ST_RESULT;
          res_taken_d = takenNow;
`ifdef FLAG_NULLIFY_EN
          null_req_d  = cond_nullify;
`endif
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
`ifdef FLAG_NULLIFY_EN
          if (res_taken_q && null_req_q) begin
            state_d = ST_NULL;
            count_d = SlotsInit;
          end
`endif
        end
      end
      ST_NULL: begin
`ifdef FLAG_NULLIFY_EN
        squash = instr_valid;
        if (instr_valid) begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, flag and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flags_q     <= 4'b0000;
      res_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      res_taken_q <= res_taken_d;
    end
  end

`ifdef FLAG_NULLIFY_EN
  // Nullify request and remaining-slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      null_req_q <= 1'b0;
      count_q    <= 4'd0;
    end else begin
      null_req_q <= null_req_d;
      count_q    <= count_d;
    end
  end
`endif

  assign flags_out  = flags_q;
  assign ci_out     = flags_q[1];
  assign cond_ready = (state_q == ST_IDLE);
  assign res_valid  = (state_q == ST_RESULT);
  assign res_taken  = res_taken_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit using a result scoreboard queue.
module tb_flag_cond_unit;

  localparam int Slots = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we;
  logic       z_in, n_in, c_in, v_in;
  logic [3:0] flags_out;
  logic       ci_out;
  logic       cond_valid;
  logic       cond_ready;
  logic [3:0] cond_code;
  logic       cond_neg;
  logic       cond_nullify;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       instr_valid;
  logic       squash;

  int compared   = 0;
  int mismatched = 0;
  bit expQ[$];

  flag_cond_unit #(.NULLIFY_SLOTS(Slots)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in),
    .flags_out(flags_out), .ci_out(ci_out),
    .cond_valid(cond_valid), .cond_ready(cond_ready), .cond_code(cond_code),
    .cond_neg(cond_neg), .cond_nullify(cond_nullify),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .instr_valid(instr_valid), .squash(squash)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic idleInputs();
    flag_we = 0; z_in = 0; n_in = 0; c_in = 0; v_in = 0;
    cond_valid = 0; cond_code = 0; cond_neg = 0; cond_nullify = 0;
    res_ready = 0; instr_valid = 0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for one edge and record the expected result.
  task automatic issueRequest(input logic [3:0] code, input bit neg, input bit nul, input bit expTaken);
    cond_valid = 1; cond_code = code; cond_neg = neg; cond_nullify = nul;
    expQ.push_back(expTaken);
    stepCycle();
    cond_valid = 0; cond_neg = 0; cond_nullify = 0; cond_code = 0;
    flag_we = 0;
  endtask

  task automatic writeFlags(input logic [3:0] f);
    flag_we = 1; {z_in, n_in, c_in, v_in} = f;
    stepCycle();
    flag_we = 0;
  endtask

  task automatic handshake();
    res_ready = 1;
    stepCycle();
    res_ready = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      flag_we = 1'($urandom_range(0, 1)); z_in = 1'($urandom_range(0, 1));
      n_in = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
      v_in = 1'($urandom_range(0, 1)); cond_valid = 1'($urandom_range(0, 1));
      cond_code = 4'($urandom_range(0, 15)); cond_nullify = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1)); instr_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    compared++;
    if ({flags_out, ci_out, cond_ready, res_valid, res_taken, squash} !== 9'b0000_0_1_0_0_0) begin
      mismatched++;
      $display("[TB] FAIL reset_state got flags=%b ci=%b rdy=%b rv=%b rt=%b sq=%b expected flags=0000 ci=0 rdy=1 rv=0 rt=0 sq=0",
               flags_out, ci_out, cond_ready, res_valid, res_taken, squash);
    end
    idleInputs();
    rst_n = 1;
    stepCycle();
  endtask

  task automatic test_flag_capture();
    logic [3:0] codes [5] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd7};
    bit         exps  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit         e;
    writeFlags(4'b0110);
    @(negedge clk);
    compared++;
    if ({flags_out, ci_out} !== 5'b0110_1) begin
      mismatched++;
      $display("[TB] FAIL flag_capture got flags=%b ci=%b expected flags=0110 ci=1", flags_out, ci_out);
    end
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      issueRequest(codes[i], 1'b0, 1'b0, exps[i]);
      @(negedge clk);
      compared++;
      if (res_valid !== 1'b1 || cond_ready !== 1'b0 || expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL code%0d_handshake got rv=%b rdy=%b queued=%0d expected rv=1 rdy=0", codes[i], res_valid, cond_ready, expQ.size());
      end else begin
        e = expQ.pop_front();
        compared++;
        if (res_taken !== e) begin
          mismatched++;
          $display("[TB] FAIL code%0d_taken got %b expected %b", codes[i], res_taken, e);
        end
      end
      stepCycle();
      handshake();
      @(negedge clk);
      compared++;
      if (cond_ready !== 1'b1 || res_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL code%0d_return_idle got rdy=%b rv=%b expected rdy=1 rv=0", codes[i], cond_ready, res_valid);
      end
      stepCycle();
    end
  endtask

  task automatic test_bypass_neg();
    logic [3:0] codes [3] = '{4'd1, 4'd9, 4'd9};
    bit         negs  [3] = '{1'b1, 1'b0, 1'b1};
    bit         exps  [3] = '{1'b0, 1'b0, 1'b1};
    bit         e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        flag_we = 1; {z_in, n_in, c_in, v_in} = 4'b1000;
      end
      issueRequest(codes[i], negs[i], 1'b0, exps[i]);
      @(negedge clk);
      if (res_valid !== 1'b1 || expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL bypass%0d_valid got rv=%b expected rv=1", i, res_valid);
      end else begin
        e = expQ.pop_front();
        compared++;
        if (res_taken !== e) begin
          mismatched++;
          $display("[TB] FAIL bypass%0d_taken got %b expected %b", i, res_taken, e);
        end
      end
      stepCycle();
      handshake();
    end
    compared++;
    if (flags_out !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL bypass_flags got %b expected 1000", flags_out);
    end
  endtask

  task automatic test_backpressure();
    bit e;
    bit zSeq [3] = '{1'b0, 1'b1, 1'b0};
    issueRequest(4'd1, 1'b0, 1'b0, 1'b1);
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL backpressure_queue got empty expected one entry");
      e = 1'b1;
    end else begin
      e = expQ.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      flag_we = 1; {z_in, n_in, c_in, v_in} = {zSeq[i], 3'b000};
      @(negedge clk);
      compared++;
      if (res_valid !== 1'b1 || res_taken !== e || cond_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL backpressure_hold%0d got rv=%b rt=%b rdy=%b expected rv=1 rt=%b rdy=0", i, res_valid, res_taken, cond_ready, e);
      end
      stepCycle();
    end
    flag_we = 0;
    handshake();
    @(negedge clk);
    compared++;
    if (cond_ready !== 1'b1 || res_valid !== 1'b0 || flags_out !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL backpressure_release got rdy=%b rv=%b flags=%b expected rdy=1 rv=0 flags=0000", cond_ready, res_valid, flags_out);
    end
    stepCycle();
  endtask

`ifdef FLAG_NULLIFY_EN
  task automatic test_nullify();
    bit ivPat  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit sqTak  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit rdyTak [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit e;
    writeFlags(4'b1000);
    for (int pass = 0; pass < 2; pass++) begin
      issueRequest(4'd1, pass[0], 1'b1, (pass == 0));
      @(negedge clk);
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL nullify%0d_queue got empty expected one entry", pass);
      end else begin
        e = expQ.pop_front();
        compared++;
        if (res_valid !== 1'b1 || res_taken !== e) begin
          mismatched++;
          $display("[TB] FAIL nullify%0d_taken got rv=%b rt=%b expected rv=1 rt=%b", pass, res_valid, res_taken, e);
        end
      end
      stepCycle();
      handshake();
      for (int i = 0; i < 4; i++) begin
        instr_valid = ivPat[i];
        @(negedge clk);
        compared++;
        if (squash !== (pass == 0 ? sqTak[i] : 1'b0) || cond_ready !== (pass == 0 ? rdyTak[i] : 1'b1)) begin
          mismatched++;
          $display("[TB] FAIL nullify%0d_slot%0d got sq=%b rdy=%b expected sq=%b rdy=%b", pass, i, squash, cond_ready,
                   (pass == 0 ? sqTak[i] : 1'b0), (pass == 0 ? rdyTak[i] : 1'b1));
        end
        stepCycle();
      end
      instr_valid = 0;
    end
  endtask

  task automatic test_reset_mid_null();
    issueRequest(4'd1, 1'b0, 1'b1, 1'b1);
    void'(expQ.pop_front());
    handshake();
    instr_valid = 1;
    stepCycle();
    @(negedge clk);
    compared++;
    if (squash !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_null_prereset got sq=%b expected 1", squash);
    end
    rst_n = 0;
    #1;
    compared++;
    if (squash !== 1'b0 || cond_ready !== 1'b1 || res_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_null_reset got sq=%b rdy=%b rv=%b expected sq=0 rdy=1 rv=0", squash, cond_ready, res_valid);
    end
    stepCycle();
    rst_n = 1;
    @(negedge clk);
    compared++;
    if (squash !== 1'b0 || cond_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_null_release got sq=%b rdy=%b expected sq=0 rdy=1", squash, cond_ready);
    end
    instr_valid = 0;
    stepCycle();
  endtask
`else
  task automatic test_nullify_disabled();
    bit e;
    writeFlags(4'b1000);
    issueRequest(4'd1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL nodis_queue got empty expected one entry");
    end else begin
      e = expQ.pop_front();
      compared++;
      if (res_valid !== 1'b1 || res_taken !== e) begin
        mismatched++;
        $display("[TB] FAIL nodis_taken got rv=%b rt=%b expected rv=1 rt=%b", res_valid, res_taken, e);
      end
    end
    stepCycle();
    handshake();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1;
      @(negedge clk);
      compared++;
      if (squash !== 1'b0 || cond_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL nodis_slot%0d got sq=%b rdy=%b expected sq=0 rdy=1", i, squash, cond_ready);
      end
      stepCycle();
    end
    instr_valid = 0;
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_flag_capture();
    test_bypass_neg();
    test_backpressure();
`ifdef FLAG_NULLIFY_EN
    test_nullify();
    test_reset_mid_null();
`else
    test_nullify_disabled();
`endif
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain got %0d left expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
